// File: rtl/baccarat_dealer_fsm_pkg.sv
// Shared types and rule constants for the baccarat dealer controller.
// Card codes are 1-13 (0 = empty); tens and face cards count as zero.
package baccarat_pkg;

  typedef enum logic [3:0] {
    START    = 4'd0,
    DEAL_P1  = 4'd1,
    DEAL_D1  = 4'd2,
    DEAL_P2  = 4'd3,
    DEAL_D2  = 4'd4,
    EVAL     = 4'd5,
    DEAL_P3  = 4'd6,
    BANK_DEC = 4'd7,
    DEAL_D3  = 4'd8,
    RESULT   = 4'd9,
    DONE     = 4'd10
  } state_t;

  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
  localparam logic [3:0] DEALER_STAND     = 4'd7;
  localparam logic [3:0] FACE_MIN         = 4'd10;

  function automatic logic [3:0] card_value(input logic [3:0] card);
    return (card >= FACE_MIN) ? 4'd0 : card;
  endfunction

endpackage

// File: rtl/baccarat_dealer_fsm_if.sv
// Controller <-> card datapath signals. master = dealer FSM, slave = datapath.
// Strobes are level signals sampled by the card registers on the clock edge that leaves the state.
interface baccarat_dealer_fsm_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic [3:0] dbg_state;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, dbg_state
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, dbg_state
  );
endinterface

// File: rtl/baccarat_dealer_fsm_banker_rule.sv
// Banker third-card table: decides whether the dealer draws after the player drew.
module baccarat_banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] i_dscore,
  input  logic [3:0] i_pcard3,
  output logic       o_draw
);

  logic [3:0] w_p3v;
  assign w_p3v = card_value(i_pcard3);

  always_comb begin
    o_draw = 1'b0;
    case (i_dscore)
      4'd0, 4'd1, 4'd2: o_draw = 1'b1;
      4'd3:             o_draw = (w_p3v != 4'd8);
      4'd4:             o_draw = (w_p3v >= 4'd2) && (w_p3v <= 4'd7);
      4'd5:             o_draw = (w_p3v >= 4'd4) && (w_p3v <= 4'd7);
      4'd6:             o_draw = (w_p3v >= 4'd6) && (w_p3v <= 4'd7);
      default:          o_draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_dealer_fsm.sv
// Punto-banco dealing sequencer: strobes the six card registers in order,
// applies the drawing rules to the datapath scores and latches the win lights.
module baccarat_dealer_fsm
  import baccarat_pkg::*;
(
  input  logic                         slow_clock,
  input  logic                         resetb,
  baccarat_dealer_fsm_if.master        bus
);

  localparam logic [3:0] S_START    = START;
  localparam logic [3:0] S_DEAL_P1  = DEAL_P1;
  localparam logic [3:0] S_DEAL_D1  = DEAL_D1;
  localparam logic [3:0] S_DEAL_P2  = DEAL_P2;
  localparam logic [3:0] S_DEAL_D2  = DEAL_D2;
  localparam logic [3:0] S_EVAL     = EVAL;
  localparam logic [3:0] S_DEAL_P3  = DEAL_P3;
  localparam logic [3:0] S_BANK_DEC = BANK_DEC;
  localparam logic [3:0] S_DEAL_D3  = DEAL_D3;
  localparam logic [3:0] S_RESULT   = RESULT;
  localparam logic [3:0] S_DONE     = DONE;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_bank_draw;
  logic       r_player_win;
  logic       r_dealer_win;

  baccarat_banker_rule u_banker_rule (
    .i_dscore (bus.dscore),
    .i_pcard3 (bus.pcard3),
    .o_draw   (w_bank_draw)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START:   w_next = S_DEAL_P1;
      S_DEAL_P1: w_next = S_DEAL_D1;
      S_DEAL_D1: w_next = S_DEAL_P2;
      S_DEAL_P2: w_next = S_DEAL_D2;
      S_DEAL_D2: w_next = S_EVAL;
      S_EVAL: begin
        if (bus.pscore >= NATURAL_MIN || bus.dscore >= NATURAL_MIN)
          w_next = S_RESULT;
        else if (bus.pscore < PLAYER_STAND_MIN)
          w_next = S_DEAL_P3;
        // Player stood: dealer uses the same stand-on-6 threshold as the player.
        else if (bus.dscore < PLAYER_STAND_MIN)
          w_next = S_DEAL_D3;
        else
          w_next = S_RESULT;
      end
      S_DEAL_P3:  w_next = S_BANK_DEC;
      S_BANK_DEC: w_next = (w_bank_draw && bus.dscore < DEALER_STAND) ? S_DEAL_D3 : S_RESULT;
      S_DEAL_D3:  w_next = S_RESULT;
      S_RESULT:   w_next = S_DONE;
      S_DONE:     w_next = S_DONE;
      default:    w_next = S_START;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state      <= S_START;
      r_player_win <= 1'b0;
      r_dealer_win <= 1'b0;
    end else begin
      r_state <= w_next;
      // A tie lights both; the >= forms cover win and tie together.
      if (r_state == S_RESULT) begin
        r_player_win <= (bus.pscore >= bus.dscore);
        r_dealer_win <= (bus.dscore >= bus.pscore);
      end
    end
  end

  assign bus.load_pcard1      = (r_state == S_DEAL_P1);
  assign bus.load_dcard1      = (r_state == S_DEAL_D1);
  assign bus.load_pcard2      = (r_state == S_DEAL_P2);
  assign bus.load_dcard2      = (r_state == S_DEAL_D2);
  assign bus.load_pcard3      = (r_state == S_DEAL_P3);
  assign bus.load_dcard3      = (r_state == S_DEAL_D3);
  assign bus.player_win_light = r_player_win;
  assign bus.dealer_win_light = r_dealer_win;
  assign bus.dbg_state        = r_state;

endmodule

// File: doc/baccarat_dealer_fsm.md
Name: baccarat_dealer_fsm

Overview:
- Sequencing controller for the baccarat card datapath.
- Drives one-hot load strobes into the six card registers: player cards 1-3 and dealer cards 1-3.
- Reads the datapath's combinational player and dealer scores and the raw player third card. Applies standard punto-banco drawing rules, then drives the win lights.
- Each card register feeds a card-to-7-segment decoder. One rising edge of slow_clock is one dealing step.

Parameters:
- None. All rule thresholds are fixed constants in the package.

Ports:
- slow_clock  input  1  Single clock; one game step per rising edge.
- resetb  input  1  Asynchronous, active-low reset.
- pscore  input  4  Player hand score 0-9, combinational from the datapath.
- dscore  input  4  Dealer hand score 0-9, combinational from the datapath.
- pcard3  input  4  Raw player third card code: 1-13, 0 = empty.
- load_pcard1, load_pcard2, load_pcard3  output  1 each  Player card register load strobes.
- load_dcard1, load_dcard2, load_dcard3  output  1 each  Dealer card register load strobes.
- player_win_light  output  1  Player wins; asserted together with dealer_win_light means tie.
- dealer_win_light  output  1  Dealer wins; asserted together with player_win_light means tie.

Behaviour:
- Reset: resetb low asynchronously forces state START, all six load outputs 0, both lights 0. Reset is honoured mid-game in any state. The first rising edge after resetb rises leaves START.
- Load outputs: Moore-decoded from state; exactly one or none high. The card register captures on the same edge that leaves the state. Scores reflecting that card are valid in the following state.
- State sequence, one state per edge: START -> DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> EVAL.
- Strobes per state:
  - DEAL_P1: load_pcard1. DEAL_D1: load_dcard1. DEAL_P2: load_pcard2. DEAL_D2: load_dcard2.
  - DEAL_P3: load_pcard3. DEAL_D3: load_dcard3.
  - EVAL, BANK_DEC, RESULT, DONE, START: no strobe.
- EVAL, natural check: if pscore >= 8 or dscore >= 8 -> RESULT.
- EVAL, player draws: else if pscore <= 5 -> DEAL_P3.
- EVAL, player stands (pscore 6 or 7): if dscore <= 5 -> DEAL_D3, else -> RESULT.
- DEAL_P3 -> BANK_DEC.
- BANK_DEC: p3v = 0 if pcard3 >= 10, else pcard3. Dealer draws when any of the following holds, else stands:
  - dscore <= 2
  - dscore == 3 and p3v != 8
  - dscore == 4 and p3v in 2..7
  - dscore == 5 and p3v in 4..7
  - dscore == 6 and p3v in 6..7
- BANK_DEC: dscore 7 always stands. Draw -> DEAL_D3; stand -> RESULT.
- DEAL_D3 -> RESULT.
- RESULT -> DONE. On that edge, register the lights:
  - player_win_light = (pscore > dscore) or (pscore == dscore)
  - dealer_win_light = (dscore > pscore) or (pscore == dscore)
- DONE: terminal. Lights hold, no strobes, until reset.
- Scores outside 0-9 are not checked. Comparisons are unsigned 4-bit.
- Latency from the first post-reset edge:
  - Natural: DONE reached at edge 7.
  - Player stands, dealer stands: edge 7.
  - Player stands, dealer draws: edge 8.
  - Player draws, dealer stands: edge 9.
  - Player draws, dealer draws: edge 10.
- Illegal state encodings recover to START.

Decomposition:
- Package baccarat_pkg holds:
  - state_t enum: START, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, DEAL_P3, BANK_DEC, DEAL_D3, RESULT, DONE.
  - Constants NATURAL_MIN=8, PLAYER_STAND_MIN=6, DEALER_STAND=7, FACE_MIN=10.
  - A card_value function mapping 1-13 to 0-9.
- One sub-module: baccarat_banker_rule. Combinational; inputs dscore and pcard3; output draw. Instantiated by the FSM for the BANK_DEC decision.

Test Plan:
- Reset mid-game: assert resetb low while in DEAL_P2, asynchronously -> all strobes 0, lights 0, state START. Release and give 1 edge -> load_pcard1=1.
- Natural: after DEAL_D2, drive pscore=9, dscore=3 -> EVAL -> RESULT -> DONE at edge 7. player_win_light=1, dealer_win_light=0. load_pcard3 and load_dcard3 never pulse.
- Player stands, dealer draws, tie: pscore=7, dscore=5 in EVAL -> DEAL_D3 pulses load_dcard3. Bench sets dscore=7 -> both lights 1 at edge 8.
- Player draws, face card, dealer draws: pscore=3, dscore=3, pcard3=12 (p3v=0) -> DEAL_P3, BANK_DEC, DEAL_D3. With final pscore=3, dscore=4 -> dealer_win_light=1 only, DONE at edge 10.
- Player draws, dealer stands: dscore=3 with pcard3=8 -> BANK_DEC -> RESULT, no load_dcard3. Also dscore=6 with pcard3=5 -> stand; dscore=6 with pcard3=7 -> draw.
- Terminal hold: after DONE, run 10 more edges -> lights unchanged, all strobes 0. A later resetb low clears the lights.
